// File: rtl/rgb_byte_packer_if.sv
// Stream bundle for rgb_byte_packer. The pixel side flows in and the byte side flows out.
// The master modport belongs to whatever feeds pixels and consumes bytes.
interface rgb_byte_packer_if #(
  parameter int IN_W       = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       mode;
  logic [IN_W-1:0]  R;
  logic [IN_W-1:0]  G;
  logic [IN_W-1:0]  B;
  logic             sof;
  logic             pixel_valid;
  logic             in_ready;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic             byte_sof;
  logic             byte_last;
  logic [LVL_W-1:0] fifo_level;

  modport master (
    output mode, R, G, B, sof, pixel_valid, byte_ready,
    input  in_ready, byte_out, byte_valid, byte_sof, byte_last, fifo_level
  );

  modport slave (
    input  mode, R, G, B, sof, pixel_valid, byte_ready,
    output in_ready, byte_out, byte_valid, byte_sof, byte_last, fifo_level
  );
endinterface

// File: rtl/rgb_byte_packer.sv
// Formats incoming RGB pixels as RGB565 / RGB888 / GRAY8, queues them in a pixel FIFO,
// and serialises each queued pixel onto an 8-bit valid/ready byte stream.
module rgb_byte_packer #(
  parameter int IN_W       = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BYTE_SWAP  = 0
) (
  input  logic              clk,
  input  logic              rst,
  rgb_byte_packer_if.slave  bus
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  typedef struct packed {
    logic        sof;
    logic [1:0]  cnt;
    logic [23:0] data;
  } entry_t;

  typedef enum logic {IDLE, SEND} state_t;

  logic [7:0] r8, g8, b8;
  logic [9:0] gray_sum;
  logic       unused_lsbs;
  entry_t     fmt;

  assign r8          = bus.R[IN_W-1 -: 8];
  assign g8          = bus.G[IN_W-1 -: 8];
  assign b8          = bus.B[IN_W-1 -: 8];
  assign gray_sum    = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};
  assign unused_lsbs = ^{bus.R, bus.G, bus.B};

  // Entries hold their bytes left-aligned, so byte k in MSB-first order is always data[23-8k -: 8].
  always_comb begin
    fmt.sof = bus.sof;
    case (bus.mode)
      2'd1: begin
        fmt.cnt  = 2'd3;
        fmt.data = {r8, g8, b8};
      end
      2'd2: begin
        fmt.cnt  = 2'd1;
        fmt.data = {gray_sum[9:2], 16'h0000};
      end
      default: begin
        fmt.cnt  = 2'd2;
        fmt.data = {r8[7:3], g8[7:2], b8[7:3], 8'h00};
      end
    endcase
  end

  function automatic logic [7:0] pick_byte(entry_t e, logic [1:0] idx);
    logic [1:0] k;
    k = (BYTE_SWAP != 0) ? (e.cnt - 2'd1 - idx) : idx;
    case (k)
      2'd0:    pick_byte = e.data[23:16];
      2'd1:    pick_byte = e.data[15:8];
      default: pick_byte = e.data[7:0];
    endcase
  endfunction

  entry_t           fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             rdy_en_q, rdy_en_d;
  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_valid_q, byte_valid_d;
  logic             byte_sof_q, byte_sof_d;
  logic             byte_last_q, byte_last_d;

  logic   full, empty, in_ready, push, pop, byte_done, load;
  logic [1:0] next_idx;
  entry_t head, after_head, load_entry;

  assign full       = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty      = (level_q == '0);
  assign in_ready   = rdy_en_q & ~full;
  assign push       = bus.pixel_valid & in_ready;
  assign byte_done  = byte_valid_q & bus.byte_ready;
  assign pop        = byte_done & byte_last_q;
  assign head       = fifo_mem[rd_ptr_q];
  assign after_head = fifo_mem[rd_ptr_q + AW'(1)];
  assign next_idx   = idx_q + 2'd1;

  // The pixel being sent stays at the FIFO head until its last byte completes, so a full
  // FIFO can never overwrite it and fifo_level counts it as occupied.
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d      = level_q + LVL_W'(push) - LVL_W'(pop);
    rdy_en_d     = 1'b1;
    state_d      = state_q;
    idx_d        = idx_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;
    byte_sof_d   = byte_sof_q;
    byte_last_d  = byte_last_q;
    load         = 1'b0;
    load_entry   = head;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          load = 1'b1;
        end
      end
      SEND: begin
        if (pop) begin
          if (level_q > LVL_W'(1)) begin
            load       = 1'b1;
            load_entry = after_head;
          end else begin
            state_d      = IDLE;
            idx_d        = 2'd0;
            byte_out_d   = 8'h00;
            byte_valid_d = 1'b0;
            byte_sof_d   = 1'b0;
            byte_last_d  = 1'b0;
          end
        end else if (byte_done) begin
          idx_d       = next_idx;
          byte_out_d  = pick_byte(head, next_idx);
          byte_sof_d  = 1'b0;
          byte_last_d = (next_idx == head.cnt - 2'd1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d      = SEND;
      idx_d        = 2'd0;
      byte_out_d   = pick_byte(load_entry, 2'd0);
      byte_valid_d = 1'b1;
      byte_sof_d   = load_entry.sof;
      byte_last_d  = (load_entry.cnt == 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= fmt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      rdy_en_q     <= 1'b0;
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      byte_sof_q   <= 1'b0;
      byte_last_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      rdy_en_q     <= rdy_en_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_sof_q   <= byte_sof_d;
      byte_last_q  <= byte_last_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_sof   = byte_sof_q;
  assign bus.byte_last  = byte_last_q;
  assign bus.fifo_level = level_q;
endmodule

// File: doc/rgb_byte_packer.md
# rgb_byte_packer

Parametrised successor to the camera-path RGB565 byte converter. Accepts one RGB pixel per cycle on a valid/ready stream and formats it as RGB565, RGB888 or GRAY8 with selectable byte order. Buffers formatted pixels in an internal FIFO and serialises them as an 8-bit byte stream toward the UDP packet builder. Single clock domain; it sits after the pixel-domain CDC, on the network-side clock.

## Interface
- IN_W, 8: bits per colour channel, 8..12; only the 8 MSBs of each channel are used.
- FIFO_DEPTH, 16: pixel FIFO entries; power of 2, at least 2.
- BYTE_SWAP, 0: 0 = MSB-first byte order (RGB565 high byte first, RGB888 sent as R,G,B); 1 = reversed.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  0 = RGB565, 1 = RGB888, 2 = GRAY8, 3 = treated as RGB565; sampled with each accepted pixel.
- R, G, B  in  IN_W each  pixel channels.
- sof  in  1  start-of-frame tag for this pixel.
- pixel_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- byte_out  out  8  output byte.
- byte_valid  out  1  byte_out valid.
- byte_ready  in  1  downstream accepts the byte.
- byte_sof  out  1  first byte of a pixel tagged sof.
- byte_last  out  1  last byte of the current pixel.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.

## Operation
- Channel reduction: r8 = R[IN_W-1 -: 8], and likewise g8 and b8.
- RGB565 word = {r8[7:3], g8[7:2], b8[7:3]}; 2 bytes.
- RGB888: 3 bytes.
- GRAY8: (r8 + 2·g8 + b8) >> 2, computed at 10-bit width, no rounding; 1 byte.
- Formatting is done before the FIFO write. Each entry holds 24 data bits, a 2-bit byte count (1..3) and sof. A mode change between pixels therefore never corrupts a pixel already accepted.
- Accept: a pixel is accepted when pixel_valid & in_ready. in_ready = !full; a pop in the same cycle does not permit a push into a full FIFO.
- Serializer states:
  - IDLE: FIFO empty, byte_valid = 0.
  - SEND: byte index idx runs 0..count-1. Byte idx is selected per BYTE_SWAP.
- Byte handshake:
  - byte_out, byte_sof and byte_last hold stable while byte_valid & !byte_ready.
  - A byte completes when byte_valid & byte_ready.
  - On completion of the last byte, the next entry is popped in the same cycle if present (no bubble); otherwise return to IDLE.
- byte_sof is set only when idx = 0 and the entry's sof is set. byte_last is set when idx = count-1 (always set in GRAY8).
- fifo_level: +1 on push, −1 on pop, unchanged on simultaneous push and pop.

## Timing
- Reset values: byte_valid 0, byte_out 0x00, byte_sof 0, byte_last 0, fifo_level 0, serializer in IDLE, FIFO empty.
- in_ready is 0 while rst is high and 1 from the first cycle after release.
- Latency: pixel accepted at edge k into an empty FIFO with byte_ready = 1 → byte_valid is 1 after edge k+1, and bytes then follow on consecutive cycles.
- Throughput: 1 byte per clk while byte_ready is high. Input sustains 1 pixel per 2 cycles (RGB565), 1 per 3 (RGB888) or 1 per cycle (GRAY8) before the FIFO fills.
- Full boundary: after FIFO_DEPTH accepts with no pops, fifo_level = FIFO_DEPTH and in_ready = 0 in the same cycle the level updates.
- Empty boundary: the last byte completes with the FIFO empty → byte_valid = 0 on the next cycle.
- Reset asserted mid-pixel: FIFO and any partially sent pixel are discarded. No byte of a discarded pixel appears after release.

## Test plan
- RGB565, BYTE_SWAP=0: R=0xFF, G=0x00, B=0xFF → bytes 0xF8, 0x1F back-to-back; byte_last only on 0x1F. With BYTE_SWAP=1 → 0x1F, 0xF8.
- RGB888, sof=1: R=0x12, G=0x34, B=0x56 → bytes 0x12, 0x34, 0x56. byte_sof set on 0x12 only; byte_last set on 0x56.
- GRAY8: R=0x40, G=0x80, B=0xC0 → single byte 0x80 with byte_last=1. A 12-bit input with R=G=B=0xFFF → 0xFF.
- Back-pressure: byte_ready=0, push 16 pixels → fifo_level=16, in_ready=0, byte_out held stable. Then byte_ready=1 → 32 bytes (RGB565) with no gaps, and in_ready returns to 1 after the first pop.
- Mode switch between pixels: one RGB565 pixel then one RGB888 pixel → 2 bytes then 3 bytes, each with the correct byte_last.
- Reset during byte 2 of an RGB888 pixel with 3 entries queued → after release byte_valid=0 and fifo_level=0; the next pixel emits correctly.
